yarvi_de: RTL and testbench
===========================

// Module: yarvi_de
// PURPOSE
//  Decode stage; sink of the fetch interface (fe_valid/fe_pc/fe_insn) and sole source of its
//  restart/restart_pc. Latches fetched insns, decodes RV32I fields, redirects fetch early on
//  JAL (and optionally backward branches), replays fetch under back-end stall, forwards ex flushes.
// PARAMETERS
//  PC_W     32            PC width; all PC arithmetic wraps mod 2^PC_W
//  INIT_PC  'h80000000    PC fetch presents first after reset; equals fetch's reset PC
// PORTS
//  clock          in   1     clock
//  reset          in   1     reset, synchronous, active-high
//  fe_valid       in   1     fetch output valid
//  fe_pc          in   PC_W  PC of fe_insn
//  fe_insn        in   32    fetched instruction
//  ex_restart     in   1     execute flush (mispredict/trap); highest priority
//  ex_restart_pc  in   PC_W  flush target
//  stall          in   1     back end cannot take de_* this cycle
//  restart        out  1     to fetch: load restart_pc (combinational)
//  restart_pc     out  PC_W  to fetch: new PC (combinational)
//  de_valid       out  1     decoded insn valid
//  de_pc, de_insn out  PC_W,32  latched PC / raw insn
//  de_rd,de_rs1,de_rs2 out 5 register fields insn[11:7],[19:15],[24:20]
//  de_imm         out  32    sign-extended imm selected by format (I/S/B/U/J; 0 for R)
//  de_pred_taken  out  1     stage redirected fetch for this insn
//  de_illegal     out  1     insn[1:0]!=2'b11 or opcode not RV32I base
// BEHAVIOUR
//  - State regs: exp_pc (next PC fetch must present), redir_pend, de_* pipeline regs.
//  - Reset: de_valid=0, de_pred_taken=0, de_illegal=0, redir_pend=0, exp_pc=INIT_PC; other de_* = 0.
//  - restart = ex_restart | redir_pend | stall.
//    restart_pc = ex_restart ? ex_restart_pc : exp_pc.
//  - accept = fe_valid & !restart. On accept (1-cycle latency): de_* <= decode(fe_pc,fe_insn),
//    de_valid<=1; exp_pc <= taken ? target : fe_pc+4; redir_pend <= taken.
//  - taken: opcode JAL -> target = fe_pc + J-imm. BRANCH with imm[12]=1 -> only under DE_BTFN_EN,
//    target = fe_pc + B-imm. JALR, illegal and all else never taken. Misaligned targets still
//    redirect; execute traps.
//  - Redirect shadow: cycle after a taken accept, fetch presents fe_pc+4 (wrong path); restart
//    is high so it is dropped; de_valid<=0 next cycle (one bubble); target accepted cycle after.
//  - Stall: all de_* and exp_pc hold; restart held to exp_pc every stalled cycle so fetch parks
//    on exp_pc; first non-stalled cycle accepts it. redir_pend clears whenever restart is high.
//  - No accept, no stall, no ex_restart: de_valid<=0, others hold.
//  - ex_restart (overrides stall, redir_pend): de_valid<=0, de_pred_taken<=0, redir_pend<=0,
//    exp_pc<=ex_restart_pc; fe output that cycle dropped.
//  - reset mid-stream overrides all; restart=0 during reset (fetch self-resets to INIT_PC).
//  - fe_valid=0 with restart=0: no accept, de_valid<=0, exp_pc holds.
// CONFIGURATION
//  DE_BTFN_EN defined: backward-taken/forward-not-taken static prediction for BRANCH as above.
//  DE_BTFN_EN undefined: branches never redirected, de_pred_taken=0 for all branches; only JAL
//  redirects. Decode/imm output identical either way.
// TESTING
//  1 reset; fe 0x80000000/0x00500093 (addi x1,x0,5) -> next cycle de_valid=1, de_pc=0x80000000,
//    de_rd=1, de_rs1=0, de_imm=5, restart=0, de_illegal=0.
//  2 fe 0x80000004/0x0100006F (jal x0,+16) -> next cycle restart=1, restart_pc=0x80000014,
//    de_pred_taken=1, fe 0x80000008 dropped; cycle after de_valid=0; then 0x80000014 accepted.
//  3 fe 0x80000100/0xFE000CE3 (beq x0,x0,-8): BTFN_EN -> restart_pc=0x800000F8, de_pred_taken=1,
//    de_imm=0xFFFFFFF8; without -> restart=0, de_pred_taken=0, 0x80000104 accepted next.
//  4 stall=1 for 3 cycles with de_valid=1 -> de_* stable, restart=1, restart_pc=exp_pc each cycle;
//    stall=0 -> insn at exp_pc latched next cycle, none skipped or duplicated.
//  5 ex_restart=1, ex_restart_pc=0x80000040 with redir_pend=1 and stall=1 -> restart_pc=0x80000040,
//    de_valid=0 next cycle, then 0x80000040 accepted.
//  6 fe insn 0x00000000 -> de_illegal=1, de_pred_taken=0, restart=0; PC at 0xFFFFFFFC with
//    jal +8 -> restart_pc=0x00000004 (wrap).

Source files
------------

// File: rtl/yarvi_de.sv
// rtl/yarvi_de.sv - RV32I decode stage: latches fetch output, decodes fields, steers fetch restarts.
// Optional DE_BTFN_EN: static backward-taken prediction for conditional branches.
module yarvi_de #(
  parameter int              PC_W    = 32,
  parameter logic [PC_W-1:0] INIT_PC = 'h80000000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            fe_valid,
  input  logic [PC_W-1:0] fe_pc,
  input  logic [31:0]     fe_insn,
  input  logic            ex_restart,
  input  logic [PC_W-1:0] ex_restart_pc,
  input  logic            stall,
  output logic            restart,
  output logic [PC_W-1:0] restart_pc,
  output logic            de_valid,
  output logic [PC_W-1:0] de_pc,
  output logic [31:0]     de_insn,
  output logic [4:0]      de_rd,
  output logic [4:0]      de_rs1,
  output logic [4:0]      de_rs2,
  output logic [31:0]     de_imm,
  output logic            de_pred_taken,
  output logic            de_illegal
);

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_MISC   = 5'b00011;
  localparam logic [4:0] OP_OPIMM  = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  logic [PC_W-1:0] exp_pc;
  logic            redir_pend;

  logic [31:0]     imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0]     imm;
  logic            legal;
  logic            taken;
  logic [PC_W-1:0] target;
  logic            accept;

  assign imm_i = {{20{fe_insn[31]}}, fe_insn[31:20]};
  assign imm_s = {{20{fe_insn[31]}}, fe_insn[31:25], fe_insn[11:7]};
  assign imm_b = {{19{fe_insn[31]}}, fe_insn[31], fe_insn[7], fe_insn[30:25], fe_insn[11:8], 1'b0};
  assign imm_u = {fe_insn[31:12], 12'h000};
  assign imm_j = {{11{fe_insn[31]}}, fe_insn[31], fe_insn[19:12], fe_insn[20], fe_insn[30:21], 1'b0};

  always_comb begin
    legal = 1'b0;
    imm   = 32'h0;
    taken = 1'b0;
    if (fe_insn[1:0] == 2'b11) begin
      case (fe_insn[6:2])
        OP_LOAD, OP_MISC, OP_OPIMM, OP_JALR, OP_SYSTEM: begin
          legal = 1'b1;
          imm   = imm_i;
        end
        OP_STORE: begin
          legal = 1'b1;
          imm   = imm_s;
        end
        OP_AUIPC, OP_LUI: begin
          legal = 1'b1;
          imm   = imm_u;
        end
        OP_OP: legal = 1'b1;
        OP_BRANCH: begin
          legal = 1'b1;
          imm   = imm_b;
`ifdef DE_BTFN_EN
          taken = fe_insn[31];
`endif
        end
        OP_JAL: begin
          legal = 1'b1;
          imm   = imm_j;
          taken = 1'b1;
        end
        default: legal = 1'b0;
      endcase
    end
  end

  // Immediate is sign-extended into the PC width so targets wrap modulo 2^PC_W.
  assign target = fe_pc + PC_W'($signed(imm));

  assign restart    = !reset && (ex_restart || redir_pend || stall);
  assign restart_pc = ex_restart ? ex_restart_pc : exp_pc;
  assign accept     = fe_valid && !restart;

  always_ff @(posedge clock) begin
    if (reset) begin
      exp_pc        <= INIT_PC;
      redir_pend    <= 1'b0;
      de_valid      <= 1'b0;
      de_pc         <= '0;
      de_insn       <= 32'h0;
      de_imm        <= 32'h0;
      de_pred_taken <= 1'b0;
      de_illegal    <= 1'b0;
    end else if (ex_restart) begin
      exp_pc        <= ex_restart_pc;
      redir_pend    <= 1'b0;
      de_valid      <= 1'b0;
      de_pred_taken <= 1'b0;
    end else if (stall) begin
      // Everything parks; fetch is held on exp_pc through restart.
      redir_pend <= 1'b0;
    end else if (redir_pend) begin
      redir_pend <= 1'b0;
      de_valid   <= 1'b0;
    end else if (accept) begin
      de_valid      <= 1'b1;
      de_pc         <= fe_pc;
      de_insn       <= fe_insn;
      de_imm        <= imm;
      de_pred_taken <= taken;
      de_illegal    <= !legal;
      exp_pc        <= taken ? target : fe_pc + PC_W'(4);
      redir_pend    <= taken;
    end else begin
      de_valid <= 1'b0;
    end
  end

  assign de_rd  = de_insn[11:7];
  assign de_rs1 = de_insn[19:15];
  assign de_rs2 = de_insn[24:20];

endmodule

// File: tb/tb_yarvi_de.sv
// tb/tb_yarvi_de.sv - directed scoreboard bench for yarvi_de (honours DE_BTFN_EN if defined).
module tb_yarvi_de;

  logic        clock = 1'b0;
  logic        reset;
  logic        fe_valid;
  logic [31:0] fe_pc;
  logic [31:0] fe_insn;
  logic        ex_restart;
  logic [31:0] ex_restart_pc;
  logic        stall;
  logic        restart;
  logic [31:0] restart_pc;
  logic        de_valid;
  logic [31:0] de_pc;
  logic [31:0] de_insn;
  logic [4:0]  de_rd, de_rs1, de_rs2;
  logic [31:0] de_imm;
  logic        de_pred_taken;
  logic        de_illegal;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        pred;
    logic        ill;
  } exp_t;

  exp_t sb[$];

`ifdef DE_BTFN_EN
  localparam logic        BTFN = 1'b1;
  localparam logic [31:0] NXT  = 32'h800000FC;
`else
  localparam logic        BTFN = 1'b0;
  localparam logic [31:0] NXT  = 32'h80000108;
`endif

  yarvi_de dut (
    .clock(clock), .reset(reset),
    .fe_valid(fe_valid), .fe_pc(fe_pc), .fe_insn(fe_insn),
    .ex_restart(ex_restart), .ex_restart_pc(ex_restart_pc), .stall(stall),
    .restart(restart), .restart_pc(restart_pc),
    .de_valid(de_valid), .de_pc(de_pc), .de_insn(de_insn),
    .de_rd(de_rd), .de_rs1(de_rs1), .de_rs2(de_rs2), .de_imm(de_imm),
    .de_pred_taken(de_pred_taken), .de_illegal(de_illegal)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] insn, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                      input logic pred, input logic ill);
    exp_t e;
    e.pc = pc; e.insn = insn; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
    e.imm = imm; e.pred = pred; e.ill = ill;
    sb.push_back(e);
  endtask

  // Drive one cycle, check combinational restart before the edge and registered outputs after it.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] insn,
                      input logic st, input logic exr, input logic [31:0] expc,
                      input logic exp_rs, input logic [31:0] exp_rpc, input logic acc);
    exp_t e;
    fe_valid = v; fe_pc = pc; fe_insn = insn;
    stall = st; ex_restart = exr; ex_restart_pc = expc;
    #1;
    chk("restart", {31'b0, restart}, {31'b0, exp_rs});
    chk("restart_pc", restart_pc, exp_rpc);
    @(posedge clock);
    #1;
    if (acc) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $error("FAIL scoreboard_empty observed=0 expected=1");
      end else begin
        e = sb.pop_front();
        chk("de_valid", {31'b0, de_valid}, 32'd1);
        chk("de_pc", de_pc, e.pc);
        chk("de_insn", de_insn, e.insn);
        chk("de_rd", {27'b0, de_rd}, {27'b0, e.rd});
        chk("de_rs1", {27'b0, de_rs1}, {27'b0, e.rs1});
        chk("de_rs2", {27'b0, de_rs2}, {27'b0, e.rs2});
        chk("de_imm", de_imm, e.imm);
        chk("de_pred_taken", {31'b0, de_pred_taken}, {31'b0, e.pred});
        chk("de_illegal", {31'b0, de_illegal}, {31'b0, e.ill});
      end
    end else if (!st || exr) begin
      chk("de_valid_bubble", {31'b0, de_valid}, 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1; fe_valid = 1'b0; fe_pc = 32'h0; fe_insn = 32'h0;
    ex_restart = 1'b0; ex_restart_pc = 32'h0; stall = 1'b1;
    #1;
    chk("restart_in_reset", {31'b0, restart}, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    chk("reset_de_valid", {31'b0, de_valid}, 32'd0);
    chk("reset_pred", {31'b0, de_pred_taken}, 32'd0);
    chk("reset_illegal", {31'b0, de_illegal}, 32'd0);
    chk("reset_de_pc", de_pc, 32'h0);
    chk("reset_de_imm", de_imm, 32'h0);
    reset = 1'b0; stall = 1'b0;

    // addi x1,x0,5
    push(32'h80000000, 32'h00500093, 5'd1, 5'd0, 5'd5, 32'd5, 1'b0, 1'b0);
    step(1, 32'h80000000, 32'h00500093, 0, 0, 0, 0, 32'h80000000, 1);
    // jal x0,+16 then wrong-path drop, bubble, target accepted
    push(32'h80000004, 32'h0100006F, 5'd0, 5'd0, 5'd16, 32'd16, 1'b1, 1'b0);
    step(1, 32'h80000004, 32'h0100006F, 0, 0, 0, 0, 32'h80000004, 1);
    step(1, 32'h80000008, 32'h00000013, 0, 0, 0, 1, 32'h80000014, 0);
    push(32'h80000014, 32'h00A00113, 5'd2, 5'd0, 5'd10, 32'd10, 1'b0, 1'b0);
    step(1, 32'h80000014, 32'h00A00113, 0, 0, 0, 0, 32'h80000014, 1);

    // beq x0,x0,-8: predicted only with backward-taken prediction
    push(32'h80000100, 32'hFE000CE3, 5'd25, 5'd0, 5'd0, 32'hFFFFFFF8, BTFN, 1'b0);
    step(1, 32'h80000100, 32'hFE000CE3, 0, 0, 0, 0, 32'h80000018, 1);
`ifdef DE_BTFN_EN
    step(1, 32'h80000104, 32'h00000013, 0, 0, 0, 1, 32'h800000F8, 0);
    push(32'h800000F8, 32'h00000013, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0);
    step(1, 32'h800000F8, 32'h00000013, 0, 0, 0, 0, 32'h800000F8, 1);
`else
    push(32'h80000104, 32'h00000013, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0);
    step(1, 32'h80000104, 32'h00000013, 0, 0, 0, 0, 32'h80000104, 1);
`endif

    // stall for three cycles: outputs frozen, fetch parked on exp_pc
    push(NXT, 32'h00308193, 5'd3, 5'd1, 5'd3, 32'd3, 1'b0, 1'b0);
    step(1, NXT, 32'h00308193, 0, 0, 0, 0, NXT, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, NXT + 32'd4, 32'h00400213, 1, 0, 0, 1, NXT + 32'd4, 0);
      chk("stall_de_valid", {31'b0, de_valid}, 32'd1);
      chk("stall_de_pc", de_pc, NXT);
      chk("stall_de_rd", {27'b0, de_rd}, 32'd3);
    end
    push(NXT + 32'd4, 32'h00400213, 5'd4, 5'd0, 5'd4, 32'd4, 1'b0, 1'b0);
    step(1, NXT + 32'd4, 32'h00400213, 0, 0, 0, 0, NXT + 32'd4, 1);

    // ex_restart overrides pending redirect and stall
    push(NXT + 32'd8, 32'h0100006F, 5'd0, 5'd0, 5'd16, 32'd16, 1'b1, 1'b0);
    step(1, NXT + 32'd8, 32'h0100006F, 0, 0, 0, 0, NXT + 32'd8, 1);
    step(1, NXT + 32'd12, 32'h00000013, 1, 1, 32'h80000040, 1, 32'h80000040, 0);
    chk("exr_pred_cleared", {31'b0, de_pred_taken}, 32'd0);
    push(32'h80000040, 32'h00500093, 5'd1, 5'd0, 5'd5, 32'd5, 1'b0, 1'b0);
    step(1, 32'h80000040, 32'h00500093, 0, 0, 0, 0, 32'h80000040, 1);

    // illegal insn, idle fetch, wrapping JAL target
    push(32'h80000044, 32'h00000000, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b1);
    step(1, 32'h80000044, 32'h00000000, 0, 0, 0, 0, 32'h80000044, 1);
    step(0, 32'h80000048, 32'h00000013, 0, 0, 0, 0, 32'h80000048, 0);
    push(32'hFFFFFFFC, 32'h0080006F, 5'd0, 5'd0, 5'd8, 32'd8, 1'b1, 1'b0);
    step(1, 32'hFFFFFFFC, 32'h0080006F, 0, 0, 0, 0, 32'h80000048, 1);
    step(0, 32'h00000000, 32'h00000013, 0, 0, 0, 1, 32'h00000004, 0);

    // reset mid-stream with stall asserted
    reset = 1'b1; stall = 1'b1; fe_valid = 1'b1;
    #1;
    chk("restart_mid_reset", {31'b0, restart}, 32'd0);
    @(posedge clock);
    #1;
    chk("mid_reset_de_valid", {31'b0, de_valid}, 32'd0);
    chk("mid_reset_restart_pc", restart_pc, 32'h80000000);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
